// File: rtl/serial_deser_pkg.sv
// serial_deser_pkg: shared definitions for the serial deserializer.
//   state_t   : framing FSM state encoding (IDLE/DATA/PARITY/STOP)
//   START_BIT : line level that begins a frame
//   STOP_BIT  : line level that must close a frame
package serial_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_deser_out_buf.sv
// deser_out_buf: one-entry valid/ready holding register for received words.
// Ports:
//   clk, rst        clock, async active-low reset
//   load            a completed word is offered this cycle
//   load_data       the offered word
//   data_ready      consumer accepts the held word
//   data_out        held word
//   data_valid      data_out holds an unconsumed word
//   blocked         buffer full and not draining this cycle (offered word would be lost)
//
// Handshake: a transfer happens on every rising edge where data_valid and
// data_ready are both 1. data_out only changes when a word is loaded, and a
// load is accepted when the buffer is empty or draining on the same edge.
module deser_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             blocked
);

    assign blocked = data_valid && !data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (load && !blocked) begin
            // Covers both "empty" and "draining while a new word arrives".
            data_out   <= load_data;
            data_valid <= 1'b1;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_deser.sv
// serial_deser: frames a same-clock serial bit stream into WIDTH-bit words.
// Line protocol: idle 0, start bit 1, WIDTH data bits LSB first,
// optional even parity bit, stop bit 0.
// Optional feature macro: SERIAL_DESER_PARITY_EN (adds the PARITY state).
// Ports:
//   clk         rising-edge clock
//   rst         async active-low reset
//   din         serial input, sampled every rising edge
//   data_out    received word (LSB = first data bit)
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts the word
//   frame_err   one-cycle pulse: stop bit sampled as 1
//   overrun     one-cycle pulse: completed word dropped, buffer full
//   parity_err  one-cycle pulse: parity mismatch (0 without the feature)
//   state       framing FSM state, for observation
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               par_bad;
    logic               stop_seen;
    logic               load;
    logic               blocked;
    logic               frame_err_d;
    logic               overrun_d;
    logic               parity_err_d;

    assign state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (din == START_BIT) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_DESER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY:  state_d = STOP;
            // A 1 in the stop slot is an error, never a fresh start bit.
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register and bit counter; data enters at the MSB so that after
    // WIDTH shifts the first bit received sits in bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: cnt_q <= '0;
                DATA: begin
                    shift_q <= {din, shift_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_DESER_PARITY_EN
    logic par_bad_q;

    // Even parity over data plus parity bit; result is held until the stop edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad_q <= 1'b0;
        end else if (state_q == PARITY) begin
            par_bad_q <= (^shift_q) ^ din;
        end
    end

    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    // Output decode: word completion and error conditions on the stop edge
    always_comb begin
        stop_seen    = (state_q == STOP);
        frame_err_d  = stop_seen && (din != STOP_BIT);
        parity_err_d = stop_seen && par_bad;
        load         = stop_seen && (din == STOP_BIT) && !par_bad;
        overrun_d    = load && blocked;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= frame_err_d;
            overrun    <= overrun_d;
            parity_err <= parity_err_d;
        end
    end

    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (shift_q),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .blocked    (blocked)
    );

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed bench for serial_deser (WIDTH=8).
// Covers reset, clean frames, frame errors, back-to-back frames, overrun,
// simultaneous drain/load, reset mid-frame and, when SERIAL_DESER_PARITY_EN
// is defined, parity accept/reject.
module tb_serial_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din = 1'b0;
    logic         data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

`ifdef SERIAL_DESER_PARITY_EN
    logic flip_par = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         stop_b;
        logic         exp_valid;
        logic         exp_ferr;
    } frame_vec_t;

    frame_vec_t vecs[6];

    serial_deser #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .state      (state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: scoreboard looks at the handshake mid-cycle, then the edge
    // is taken and outputs are stable 1 time unit later.
    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        if (data_valid && data_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %0h expected none", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL sb_word: got %0h expected %0h", data_out, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick();
    endtask

    // Start bit, data bits and (optionally) parity; the stop bit is left to the caller.
    task automatic send_head(input logic [W-1:0] d);
        send_bit(1'b1);
        for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef SERIAL_DESER_PARITY_EN
        send_bit((^d) ^ flip_par);
`endif
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_b);
        send_head(d);
        send_bit(stop_b);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1};

        // reset
        tick();
        tick();
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        rst = 1'b1;
        tick();

        // table-driven frames, consumer always ready
        data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_head(vecs[i].data);
            chk("pre_stop_valid", 32'(data_valid), 32'd0);
            din = vecs[i].stop_b;
            tick();
            chk("stop_valid", 32'(data_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk("stop_data", 32'(data_out), 32'(vecs[i].data));
                exp_q.push_back(vecs[i].data);
            end
            chk("stop_ferr", 32'(frame_err), 32'(vecs[i].exp_ferr));
            chk("stop_overrun", 32'(overrun), 32'd0);
            chk("stop_perr", 32'(parity_err), 32'd0);
            chk("stop_state", 32'(state), 32'd0);
            din = 1'b0;
            tick();
            chk("valid_one_cycle", 32'(data_valid), 32'd0);
            chk("ferr_pulse_end", 32'(frame_err), 32'd0);
            chk("idle_state", 32'(state), 32'd0);
        end

        // back-to-back frames, no idle gap
        send_frame(8'hC3, 1'b0);
        chk("b2b_first", 32'(data_out), 32'hC3);
        exp_q.push_back(8'hC3);
        send_frame(8'h3A, 1'b0);
        chk("b2b_valid", 32'(data_valid), 32'd1);
        chk("b2b_second", 32'(data_out), 32'h3A);
        exp_q.push_back(8'h3A);
        din = 1'b0;
        tick();

        // overrun under backpressure
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        chk("bp_valid", 32'(data_valid), 32'd1);
        chk("bp_data", 32'(data_out), 32'h11);
        send_frame(8'h22, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_hold_data", 32'(data_out), 32'h11);
        chk("ovr_hold_valid", 32'(data_valid), 32'd1);
        din = 1'b0;
        tick();
        chk("ovr_pulse_end", 32'(overrun), 32'd0);
        chk("ovr_still_held", 32'(data_out), 32'h11);
        exp_q.push_back(8'h11);
        data_ready = 1'b1;
        tick();
        chk("ovr_drained", 32'(data_valid), 32'd0);

        // simultaneous drain and load
        data_ready = 1'b0;
        send_frame(8'h33, 1'b0);
        chk("sim_hold", 32'(data_out), 32'h33);
        send_head(8'h44);
        exp_q.push_back(8'h33);
        din = 1'b0;
        data_ready = 1'b1;
        tick();
        chk("sim_valid", 32'(data_valid), 32'd1);
        chk("sim_data", 32'(data_out), 32'h44);
        chk("sim_no_ovr", 32'(overrun), 32'd0);
        exp_q.push_back(8'h44);
        tick();
        chk("sim_drained", 32'(data_valid), 32'd0);

        // reset in the middle of a frame while a word is held
        data_ready = 1'b0;
        send_frame(8'h99, 1'b0);
        chk("mid_held", 32'(data_valid), 32'd1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        din = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel_state", 32'(state), 32'd0);
        chk("mid_rel_valid", 32'(data_valid), 32'd0);
        chk("mid_rel_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        send_frame(8'h3C, 1'b0);
        chk("mid_next_valid", 32'(data_valid), 32'd1);
        chk("mid_next_data", 32'(data_out), 32'h3C);
        exp_q.push_back(8'h3C);
        din = 1'b0;
        data_ready = 1'b1;
        tick();
        chk("mid_next_drained", 32'(data_valid), 32'd0);

`ifdef SERIAL_DESER_PARITY_EN
        // parity accept / reject
        send_frame(8'h07, 1'b0);
        chk("par_ok_valid", 32'(data_valid), 32'd1);
        chk("par_ok_data", 32'(data_out), 32'h07);
        chk("par_ok_perr", 32'(parity_err), 32'd0);
        exp_q.push_back(8'h07);
        din = 1'b0;
        tick();
        flip_par = 1'b1;
        send_frame(8'h07, 1'b0);
        chk("par_bad_perr", 32'(parity_err), 32'd1);
        chk("par_bad_valid", 32'(data_valid), 32'd0);
        chk("par_bad_ferr", 32'(frame_err), 32'd0);
        din = 1'b0;
        tick();
        chk("par_bad_end", 32'(parity_err), 32'd0);
        flip_par = 1'b0;
`endif

        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Downstream consumer of the single-bit registered stream produced by the team's d_flipflop (`q` feeds `din`).
- Frames the same-clock serial bit stream, one bit per clock.
- Shifts WIDTH data bits into a word and presents the word on a valid/ready output with a one-entry holding buffer.
- Flags framing errors and overruns as one-cycle pulses.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- CNT_W, 5, width of the internal bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream flop.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- din  input  1  serial bit stream from upstream flop `q`, sampled every rising clk edge.
- data_out  output  WIDTH  received word, LSB = first data bit.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, shift register=0, bit counter=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, parity_err=0.
  - Any partial frame is discarded; a held word is lost.
- Line protocol:
  - Idle level 0, start bit 1.
  - WIDTH data bits, LSB first.
  - Optional parity bit (see Optional Feature).
  - Stop bit 0.
- State machine (all transitions on rising clk):
  - IDLE: din=1 → DATA, counter=0. din=0 → stay in IDLE.
  - DATA: shift din into the MSB end of the shift register (right shift), counter++. On the WIDTH-th data bit → STOP (or PARITY).
  - STOP, din=0: word complete → IDLE.
  - STOP, din=1: frame_err=1 for one cycle, word dropped → IDLE. This 1 is NOT taken as a new start bit.
- Word completion:
  - Occurs on the edge sampling the stop bit, i.e. WIDTH+1 edges after the start-bit edge.
  - If the buffer is empty, or draining on this edge (data_valid & data_ready): data_out ← word, data_valid=1 from this edge.
  - Otherwise: overrun=1 for one cycle; the new word is dropped; the held word and data_valid are unchanged.
- Handshake:
  - Transfer occurs on an edge where data_valid & data_ready.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_valid falls after a transfer unless a new word loads on the same edge, in which case data_valid stays 1 and data_out takes the new word.
  - data_ready while data_valid=0 has no effect.
- Back-to-back frames: a start bit may be presented on the cycle immediately after a stop bit; no idle gap is required.
- Error pulses: all error outputs are registered, asserted for exactly one cycle, and never coincident with a word load.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP; frame length becomes WIDTH+3 bits.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - On mismatch: parity_err pulses on the stop-sampling edge; the word is dropped; frame_err still applies independently.
  - Word completion occurs WIDTH+2 edges after the start edge.
- Undefined:
  - No PARITY state; parity_err is tied to 0.

Decomposition:
- Shared package/include holds:
  - State encoding constants: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - START_BIT=1'b1, STOP_BIT=1'b0.
- One sub-module: deser_out_buf.
  - One-entry valid/ready holding register.
  - Inputs: load, load_data, data_ready.
  - Outputs: data_out, data_valid, and a full-and-not-draining indication used to generate overrun.
- Framing FSM, shift register and counter live in serial_deser.

Test Plan:
- Reset mid-frame: rst=0 after 4 data bits, released while din=0 → data_valid=0, state IDLE, no error pulses; the next clean frame of 0x3C is received as 0x3C.
- Frame 0xA5 with data_ready=1: din = 1, then 1,0,1,0,0,1,0,1, then 0 → data_out=0xA5, data_valid=1 for one cycle, starting 9 edges after the start edge.
- Frame with stop bit = 1 → frame_err pulses once; data_valid stays 0; the following 0x5A frame is received correctly.
- data_ready=0; frames 0x11 then 0x22 back-to-back:
  - data_out holds 0x11.
  - overrun pulses at the completion of 0x22.
  - After data_ready=1, 0x11 is consumed and data_valid=0.
- Simultaneous drain/load: buffer holds 0x33; data_ready rises on the 0x44 stop-bit edge → data_valid stays 1 and data_out=0x44 with no overrun.
- With SERIAL_DESER_PARITY_EN, frame 0x07 (parity bit 1) is accepted. The same frame with parity bit 0 gives a parity_err pulse and no data_valid.
